// File: rtl/hbd_coeff_sequencer.sv
// hbd_coeff_sequencer
//   Loads a block of coefficients from a settings-bus shadow table into a
//   half-band decimator. The decimator is paused while the load runs. It is
//   then flushed with a fixed number of input strobes before its output is
//   trusted again.
//
// Ports
//   clock        sole clock
//   reset        synchronous, active-high reset
//   set_stb      settings write strobe
//   set_addr     settings address (BASE = shadow write, BASE+1 = commit)
//   set_data     settings data ([20:16] entry, [15:0] value; [0] commit)
//   strobe_in    upstream sample strobe
//   strobe_filt  strobe_in delayed one cycle, gated by filt_enable
//   filt_enable  decimator enable (low in QUIESCE and LOAD)
//   out_valid    decimator output trustworthy (IDLE only)
//   coeff_write  coefficient write strobe (LOAD only)
//   coeff_addr   coefficient index, holds last value outside LOAD
//   coeff_data   coefficient value, holds last value outside LOAD
//   busy         sequencer not in IDLE
//   done         one-cycle pulse when a load sequence completes
//   error        sticky protocol-violation flag, cleared by an accepted commit
module hbd_coeff_sequencer #(
  parameter logic [7:0] BASE          = 8'd0,
  parameter int         NUM_TAPS      = 16,
  parameter int         FLUSH_STROBES = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        set_stb,
  input  logic [7:0]  set_addr,
  input  logic [31:0] set_data,
  input  logic        strobe_in,
  output logic        strobe_filt,
  output logic        filt_enable,
  output logic        out_valid,
  output logic        coeff_write,
  output logic [4:0]  coeff_addr,
  output logic [15:0] coeff_data,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_QUIESCE = 2'd1;
  localparam logic [1:0] S_LOAD    = 2'd2;
  localparam logic [1:0] S_FLUSH   = 2'd3;

  localparam logic [7:0]    COMMIT_ADDR = BASE + 8'd1;
  localparam logic [5:0]    TAPS        = 6'(NUM_TAPS);
  localparam int            FW          = $clog2(FLUSH_STROBES + 1);
  localparam logic [FW-1:0] FLUSH_N     = FW'(FLUSH_STROBES);

  // Flush strobe counter never counts past FLUSH_STROBES.
  function automatic logic [FW-1:0] sat_inc(input logic [FW-1:0] v);
    return (v >= FLUSH_N) ? FLUSH_N : v + 1'b1;
  endfunction

  logic [1:0]    state_q, state_d;
  logic [5:0]    load_cnt_q, load_cnt_d;
  logic [FW-1:0] flush_cnt_q, flush_cnt_d;
  logic [15:0]   shadow_q [32];
  logic [15:0]   shadow_d [32];
  logic          error_q, error_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;
  logic          filt_enable_q, filt_enable_d;
  logic          out_valid_q, out_valid_d;
  logic          strobe_filt_q, strobe_filt_d;
  logic          coeff_write_q, coeff_write_d;
  logic [4:0]    coeff_addr_q, coeff_addr_d;
  logic [15:0]   coeff_data_q, coeff_data_d;

  logic wr_hit, commit_hit;
  logic unused_set_bits;

  assign wr_hit          = set_stb && (set_addr == BASE);
  assign commit_hit      = set_stb && (set_addr == COMMIT_ADDR) && set_data[0];
  assign unused_set_bits = ^set_data[31:21];

  always_comb begin
    state_d       = state_q;
    load_cnt_d    = load_cnt_q;
    flush_cnt_d   = flush_cnt_q;
    shadow_d      = shadow_q;
    error_d       = error_q;
    done_d        = 1'b0;
    coeff_write_d = 1'b0;
    coeff_addr_d  = coeff_addr_q;
    coeff_data_d  = coeff_data_q;

    // Shadow table is frozen while it is being streamed out.
    if (wr_hit) begin
      if (state_q == S_LOAD) error_d = 1'b1;
      else                   shadow_d[set_data[20:16]] = set_data[15:0];
    end

    if (commit_hit && state_q != S_IDLE) error_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (commit_hit) begin
          state_d = S_QUIESCE;
          error_d = 1'b0;
        end
      end
      // QUIESCE waits out upstream strobe activity; a strobe here delays
      // the load rather than being lost. Reading shadow_d lets a write in
      // this same cycle to entry 0 reach the first coefficient.
      S_QUIESCE: begin
        if (!strobe_in) begin
          state_d       = S_LOAD;
          coeff_write_d = 1'b1;
          coeff_addr_d  = 5'd0;
          coeff_data_d  = shadow_d[0];
          load_cnt_d    = 6'd1;
        end
      end
      // load_cnt_q is the index to present on the next cycle.
      S_LOAD: begin
        if (strobe_in) error_d = 1'b1;
        if (load_cnt_q == TAPS) begin
          state_d     = S_FLUSH;
          load_cnt_d  = '0;
          flush_cnt_d = '0;
        end else begin
          coeff_write_d = 1'b1;
          coeff_addr_d  = load_cnt_q[4:0];
          coeff_data_d  = shadow_d[load_cnt_q[4:0]];
          load_cnt_d    = load_cnt_q + 6'd1;
        end
      end
      S_FLUSH: begin
        if (strobe_in) begin
          flush_cnt_d = sat_inc(flush_cnt_q);
          if (flush_cnt_d == FLUSH_N) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    filt_enable_d = (state_d == S_IDLE) || (state_d == S_FLUSH);
    out_valid_d   = (state_d == S_IDLE);
    busy_d        = (state_d != S_IDLE);
    // Gate with the enable in force when the strobe arrived.
    strobe_filt_d = strobe_in && filt_enable_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      load_cnt_q    <= '0;
      flush_cnt_q   <= '0;
      error_q       <= 1'b0;
      done_q        <= 1'b0;
      busy_q        <= 1'b0;
      filt_enable_q <= 1'b1;
      out_valid_q   <= 1'b1;
      strobe_filt_q <= 1'b0;
      coeff_write_q <= 1'b0;
      coeff_addr_q  <= '0;
      coeff_data_q  <= '0;
      for (int i = 0; i < 32; i++) shadow_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      load_cnt_q    <= load_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
      error_q       <= error_d;
      done_q        <= done_d;
      busy_q        <= busy_d;
      filt_enable_q <= filt_enable_d;
      out_valid_q   <= out_valid_d;
      strobe_filt_q <= strobe_filt_d;
      coeff_write_q <= coeff_write_d;
      coeff_addr_q  <= coeff_addr_d;
      coeff_data_q  <= coeff_data_d;
      shadow_q      <= shadow_d;
    end
  end

  assign strobe_filt = strobe_filt_q;
  assign filt_enable = filt_enable_q;
  assign out_valid   = out_valid_q;
  assign coeff_write = coeff_write_q;
  assign coeff_addr  = coeff_addr_q;
  assign coeff_data  = coeff_data_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;

endmodule

// File: tb/tb_hbd_coeff_sequencer.sv
// Testbench for hbd_coeff_sequencer: directed scenarios plus random traffic,
// checked against a transaction-level model through a scoreboard.
module tb_hbd_coeff_sequencer;

  localparam logic [7:0] BASE = 8'h40;
  localparam int NT = 16;
  localparam int FS = 16;

  localparam int K_NONE = 0, K_WR = 1, K_COMMIT = 2, K_OTHER = 3, K_NOCOMMIT = 4;
  localparam int M_IDLE = 0, M_QUI = 1, M_LOAD = 2, M_FLUSH = 3;

  logic        clock = 1'b0;
  logic        reset;
  logic        set_stb;
  logic [7:0]  set_addr;
  logic [31:0] set_data;
  logic        strobe_in;
  logic        strobe_filt, filt_enable, out_valid, coeff_write;
  logic [4:0]  coeff_addr;
  logic [15:0] coeff_data;
  logic        busy, done, error;

  hbd_coeff_sequencer #(.BASE(BASE), .NUM_TAPS(NT), .FLUSH_STROBES(FS)) dut (
    .clock(clock), .reset(reset), .set_stb(set_stb), .set_addr(set_addr),
    .set_data(set_data), .strobe_in(strobe_in), .strobe_filt(strobe_filt),
    .filt_enable(filt_enable), .out_valid(out_valid), .coeff_write(coeff_write),
    .coeff_addr(coeff_addr), .coeff_data(coeff_data), .busy(busy), .done(done),
    .error(error)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [4:0]  addr;
    logic [15:0] data;
  } wr_t;

  typedef struct packed {
    logic filt_en;
    logic out_valid;
    logic busy;
    logic done;
    logic error;
    logic strobe_filt;
    logic coeff_write;
  } st_t;

  wr_t coeff_q[$];
  st_t st_q[$];

  int n_checks = 0;
  int n_fail = 0;
  int n_done_exp = 0;
  int n_done_seen = 0;
  logic [15:0] seen_a3 = 16'd0;

  // Reference model: which phase the sequencer is in, which tap is on the
  // bus, how many flush strobes have been seen, and the shadow table.
  int          m_mode = M_IDLE;
  int          m_k = 0;
  int          m_seen = 0;
  logic        m_err = 1'b0;
  logic [15:0] m_shadow [32];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Predict the outputs that follow the coming clock edge.
  task automatic model_step(input logic rst, input logic stb, input int kind,
                            input int idx, input logic [15:0] val);
    st_t  e;
    logic fe_now;
    logic dn;
    logic sf;
    fe_now = (m_mode == M_IDLE) || (m_mode == M_FLUSH);
    dn = 1'b0;
    sf = 1'b0;
    if (rst) begin
      m_mode = M_IDLE;
      m_k = 0;
      m_seen = 0;
      m_err = 1'b0;
      for (int i = 0; i < 32; i++) m_shadow[i] = 16'd0;
    end else begin
      sf = stb && fe_now;
      if (kind == K_WR) begin
        if (m_mode == M_LOAD) m_err = 1'b1;
        else m_shadow[idx] = val;
      end
      if (kind == K_COMMIT && m_mode != M_IDLE) m_err = 1'b1;
      case (m_mode)
        M_IDLE: if (kind == K_COMMIT) begin m_mode = M_QUI; m_err = 1'b0; end
        M_QUI: if (!stb) begin m_mode = M_LOAD; m_k = 0; end
        M_LOAD: begin
          if (stb) m_err = 1'b1;
          if (m_k == NT - 1) begin m_mode = M_FLUSH; m_seen = 0; end
          else m_k++;
        end
        default: if (stb) begin
          m_seen++;
          if (m_seen == FS) begin m_mode = M_IDLE; dn = 1'b1; end
        end
      endcase
      if (m_mode == M_LOAD) begin
        wr_t w;
        w.addr = 5'(m_k);
        w.data = m_shadow[m_k];
        coeff_q.push_back(w);
      end
    end
    if (dn) n_done_exp++;
    e.filt_en     = (m_mode == M_IDLE) || (m_mode == M_FLUSH);
    e.out_valid   = (m_mode == M_IDLE);
    e.busy        = (m_mode != M_IDLE);
    e.done        = dn;
    e.error       = m_err;
    e.strobe_filt = sf;
    e.coeff_write = (m_mode == M_LOAD);
    st_q.push_back(e);
  endtask

  // One clock cycle of stimulus; returns 1 time unit after the edge.
  task automatic cyc(input logic rst, input logic stb, input int kind,
                     input int idx = 0, input logic [15:0] val = 16'd0);
    reset = rst;
    strobe_in = stb;
    set_stb = (kind != K_NONE);
    case (kind)
      K_WR:       begin set_addr = BASE;         set_data = {11'd0, 5'(idx), val}; end
      K_COMMIT:   begin set_addr = BASE + 8'd1;  set_data = 32'h0000_0001; end
      K_NOCOMMIT: begin set_addr = BASE + 8'd1;  set_data = 32'h0000_0002; end
      K_OTHER:    begin set_addr = BASE + 8'd7;  set_data = 32'hFFFF_FFFF; end
      default:    begin set_addr = 8'h00;        set_data = 32'h0; end
    endcase
    model_step(rst, stb, kind, idx, val);
    @(posedge clock);
    #1;
  endtask

  task automatic run_until_idle(input int period);
    int c;
    c = 0;
    while (m_mode != M_IDLE) begin
      cyc(1'b0, (c % period) == period - 1, K_NONE);
      c++;
      if (c > 2000) begin
        n_checks++;
        n_fail++;
        $display("FAIL run_until_idle timeout actual=%0d required=idle", m_mode);
        break;
      end
    end
  endtask

  task automatic wait_for(input int mode, input int k);
    int c;
    c = 0;
    while (!(m_mode == mode && (k < 0 || m_k == k))) begin
      cyc(1'b0, 1'b0, K_NONE);
      c++;
      if (c > 200) begin
        n_checks++;
        n_fail++;
        $display("FAIL wait_for timeout actual=%0d required=%0d", m_mode, mode);
        break;
      end
    end
  endtask

  // Scoreboard monitor: one status record per cycle, one coefficient
  // record per coeff_write.
  always @(negedge clock) begin : monitor
    st_t e;
    st_t a;
    wr_t w;
    if (st_q.size() > 0) begin
      e = st_q.pop_front();
      a.filt_en     = filt_enable;
      a.out_valid   = out_valid;
      a.busy        = busy;
      a.done        = done;
      a.error       = error;
      a.strobe_filt = strobe_filt;
      a.coeff_write = coeff_write;
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL status t=%0t actual=%b required=%b (fe,ov,busy,done,err,sf,cw)",
                 $time, a, e);
      end
    end
    if (done === 1'b1) n_done_seen++;
    if (coeff_write === 1'b1) begin
      if (coeff_addr == 5'd3) seen_a3 = coeff_data;
      n_checks++;
      if (coeff_q.size() == 0) begin
        n_fail++;
        $display("FAIL coeff_unexpected actual=%0d:%h required=none", coeff_addr, coeff_data);
      end else begin
        w = coeff_q.pop_front();
        if ({coeff_addr, coeff_data} !== w) begin
          n_fail++;
          $display("FAIL coeff_write actual=%0d:%h required=%0d:%h",
                   coeff_addr, coeff_data, w.addr, w.data);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 32; i++) m_shadow[i] = 16'd0;
    reset = 1'b1; set_stb = 1'b0; set_addr = 8'h00; set_data = 32'h0; strobe_in = 1'b0;

    // Reset state
    cyc(1'b1, 1'b0, K_NONE);
    cyc(1'b1, 1'b0, K_NONE);
    chk("reset_coeff_addr", 32'(coeff_addr), 32'd0);
    chk("reset_coeff_data", 32'(coeff_data), 32'd0);
    cyc(1'b0, 1'b0, K_NONE);

    // Basic load: entries 100+k, ignored bus traffic, strobe idle at commit
    for (int k = 0; k < NT; k++) cyc(1'b0, 1'b0, K_WR, k, 16'(100 + k));
    cyc(1'b0, 1'b0, K_OTHER);
    cyc(1'b0, 1'b0, K_NOCOMMIT);
    cyc(1'b0, 1'b0, K_COMMIT);
    for (int i = 0; i < NT + 2; i++) cyc(1'b0, 1'b0, K_NONE);
    run_until_idle(2);
    cyc(1'b0, 1'b0, K_NONE);
    chk("hold_coeff_addr", 32'(coeff_addr), 32'd15);
    chk("hold_coeff_data", 32'(coeff_data), 32'd115);

    // Commit with strobe_in high for three cycles
    cyc(1'b0, 1'b1, K_COMMIT);
    cyc(1'b0, 1'b1, K_NONE);
    cyc(1'b0, 1'b1, K_NONE);
    cyc(1'b0, 1'b0, K_NONE);
    chk("quiesce_then_load", 32'(coeff_write), 32'd1);
    run_until_idle(3);

    // Strobes every third clock during LOAD
    cyc(1'b0, 1'b0, K_COMMIT);
    cyc(1'b0, 1'b0, K_NONE);
    for (int i = 0; i < NT; i++) cyc(1'b0, (i % 3) == 0, K_NONE);
    run_until_idle(1);
    chk("error_after_drops", 32'(error), 32'd1);

    // Second commit during FLUSH (the first commit clears error)
    cyc(1'b0, 1'b0, K_COMMIT);
    chk("commit_clears_error", 32'(error), 32'd0);
    wait_for(M_FLUSH, -1);
    cyc(1'b0, 1'b1, K_NONE);
    cyc(1'b0, 1'b0, K_COMMIT);
    run_until_idle(2);

    // Shadow write to entry 3 during LOAD, then during FLUSH
    cyc(1'b0, 1'b0, K_COMMIT);
    wait_for(M_LOAD, 1);
    cyc(1'b0, 1'b0, K_WR, 3, 16'h7FFF);
    run_until_idle(2);
    cyc(1'b0, 1'b0, K_COMMIT);
    run_until_idle(2);
    chk("addr3_kept_old", 32'(seen_a3), 32'd103);
    cyc(1'b0, 1'b0, K_COMMIT);
    wait_for(M_FLUSH, -1);
    cyc(1'b0, 1'b0, K_WR, 3, 16'h7FFF);
    run_until_idle(2);
    cyc(1'b0, 1'b0, K_COMMIT);
    run_until_idle(2);
    chk("addr3_new_value", 32'(seen_a3), 32'h7FFF);

    // Reset at LOAD cycle 5, then a full load from index 0
    cyc(1'b0, 1'b0, K_COMMIT);
    wait_for(M_LOAD, 5);
    cyc(1'b1, 1'b0, K_NONE);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_coeff_write", 32'(coeff_write), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, K_NONE);
    cyc(1'b0, 1'b0, K_WR, 0, 16'hA5A5);
    cyc(1'b0, 1'b0, K_WR, 15, 16'h5A5A);
    cyc(1'b0, 1'b0, K_COMMIT);
    run_until_idle(2);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      int r;
      int kind;
      logic rst;
      r = $urandom_range(0, 99);
      if (r < 85)      kind = K_NONE;
      else if (r < 93) kind = K_WR;
      else if (r < 96) kind = K_COMMIT;
      else if (r < 98) kind = K_OTHER;
      else             kind = K_NOCOMMIT;
      if (m_mode == M_IDLE && $urandom_range(0, 9) == 0) kind = K_COMMIT;
      rst = ($urandom_range(0, 599) == 0);
      cyc(rst, $urandom_range(0, 3) == 0, kind, $urandom_range(0, 31), 16'($urandom));
    end
    run_until_idle(2);

    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, K_NONE);
    @(negedge clock);
    @(negedge clock);
    chk("coeff_queue_drained", 32'(coeff_q.size()), 32'd0);
    chk("done_pulse_count", 32'(n_done_seen), 32'(n_done_exp));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
